wb_commit_queue: RTL and testbench

//  Parametrised write-back/commit stage. Buffers completed instructions from MEM in an in-order queue,

---
 rtl/wb_pkg.sv | 55 +++++
 rtl/wb_load_align.sv | 44 ++++
 rtl/wb_commit_queue.sv | 173 +++++++++++++++++
 tb/tb_wb_commit_queue.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared types for the write-back / commit stage.
//   wb_entry_t  - one queued completed instruction
//   rvfi_pkt_t  - retirement trace packet (used when WB_COMMIT_RVFI_EN is defined)
//   F3_*        - load funct3 encodings
//   ptr_w()     - pointer width for a power-of-two queue depth
// Optional feature macro: WB_COMMIT_RVFI_EN (adds trace fields to each entry).
package wb_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    function automatic int ptr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    typedef struct packed {
        logic        load_rf;
        logic [4:0]  rd;
        logic        is_load;
        logic [2:0]  funct3;
        logic [1:0]  addr_lo;
        logic [31:0] result;
        logic [31:0] rdata;
`ifdef WB_COMMIT_RVFI_EN
        logic [31:0] pc;
        logic [31:0] insn;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] pc_wdata;
        logic [31:0] mem_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
        logic [31:0] mem_wdata;
`endif
    } wb_entry_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] insn;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic [31:0] pc_rdata;
        logic [31:0] pc_wdata;
        logic [31:0] mem_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
        logic [31:0] mem_wdata;
    } rvfi_pkt_t;

endpackage

// File: rtl/wb_load_align.sv
// wb_load_align: combinational load-data extraction.
//   funct3, addr_lo, rdata in -> wdata (aligned, extended), misaligned out.
// Misaligned halfword/word accesses return data as if the low address bits
// were cleared; unknown load encodings behave as LW.
module wb_load_align
    import wb_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic        misaligned
);

    logic [31:0] shifted;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign shifted = rdata >> {addr_lo, 3'b000};
    assign byte_v  = shifted[7:0];
    assign half_v  = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        wdata      = rdata;
        misaligned = 1'b0;
        case (funct3)
            F3_LB:  wdata = {{24{byte_v[7]}}, byte_v};
            F3_LBU: wdata = {24'h0, byte_v};
            F3_LH: begin
                wdata      = {{16{half_v[15]}}, half_v};
                misaligned = addr_lo[0];
            end
            F3_LHU: begin
                wdata      = {16'h0, half_v};
                misaligned = addr_lo[0];
            end
            default: begin
                wdata      = rdata;
                misaligned = (addr_lo != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/wb_commit_queue.sv
// wb_commit_queue: in-order write-back/commit queue.
//   in_*         - completed instruction from MEM (valid/ready handshake)
//   wb_stall     - holds commit
//   rf_we/rf_rd/rf_wdata - registered regfile write, one per cycle max
//   pending_mask - rd bits with an uncommitted write (queue + output reg)
//   instret      - retired instruction count
//   misalign_err - sticky misaligned LH/LHU/LW commit flag
// Optional feature macro: WB_COMMIT_RVFI_EN adds trace inputs and rvfi_o.
module wb_commit_queue
    import wb_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [4:0]       in_rd,
    input  logic             in_load_rf,
    input  logic             in_is_load,
    input  logic [2:0]       in_funct3,
    input  logic [1:0]       in_addr_lo,
    input  logic [XLEN-1:0]  in_result,
    input  logic [XLEN-1:0]  in_rdata,
    input  logic             wb_stall,
    output logic             rf_we,
    output logic [4:0]       rf_rd,
    output logic [XLEN-1:0]  rf_wdata,
    output logic [31:0]      pending_mask,
    output logic [CNT_W-1:0] instret,
    output logic             misalign_err
`ifdef WB_COMMIT_RVFI_EN
    ,
    input  logic [31:0]      in_insn,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [31:0]      in_pc_wdata,
    input  logic [31:0]      in_mem_addr,
    input  logic [3:0]       in_mem_rmask,
    input  logic [3:0]       in_mem_wmask,
    input  logic [31:0]      in_mem_wdata,
    output rvfi_pkt_t        rvfi_o
`endif
);

    localparam int PW = ptr_w(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    wb_entry_t   q [DEPTH];
    wb_entry_t   in_e, head_e;
    logic [PW-1:0] head, tail, off;
    logic [PW:0]   count;
    logic          do_enq, do_deq;
    logic [31:0]   al_wdata;
    logic          al_mis;

    assign in_ready = (count != FULL_CNT);
    assign do_enq   = in_valid && in_ready;
    assign do_deq   = (count != '0) && !wb_stall;
    assign head_e   = q[head];

    always_comb begin
        in_e         = '0;
        in_e.load_rf = in_load_rf;
        in_e.rd      = in_rd;
        in_e.is_load = in_is_load;
        in_e.funct3  = in_funct3;
        in_e.addr_lo = in_addr_lo;
        in_e.result  = in_result;
        in_e.rdata   = in_rdata;
`ifdef WB_COMMIT_RVFI_EN
        in_e.pc        = in_pc;
        in_e.insn      = in_insn;
        in_e.rs1       = in_rs1;
        in_e.rs2       = in_rs2;
        in_e.pc_wdata  = in_pc_wdata;
        in_e.mem_addr  = in_mem_addr;
        in_e.mem_rmask = in_mem_rmask;
        in_e.mem_wmask = in_mem_wmask;
        in_e.mem_wdata = in_mem_wdata;
`endif
    end

`ifndef WB_COMMIT_RVFI_EN
    // PC only travels with the trace packet.
    logic unused_pc;
    assign unused_pc = ^in_pc;
`endif

    wb_load_align u_align (
        .funct3     (head_e.funct3),
        .addr_lo    (head_e.addr_lo),
        .rdata      (head_e.rdata),
        .wdata      (al_wdata),
        .misaligned (al_mis)
    );

    // Storage needs no reset: entries are only read when count says valid.
    always_ff @(posedge clk) begin
        if (do_enq) q[tail] <= in_e;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            rf_we        <= 1'b0;
            rf_rd        <= '0;
            rf_wdata     <= '0;
            instret      <= '0;
            misalign_err <= 1'b0;
        end else begin
            if (do_enq) tail <= tail + 1'b1;
            if (do_deq) head <= head + 1'b1;
            case ({do_enq, do_deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            rf_we <= do_deq && head_e.load_rf && (head_e.rd != 5'd0);
            if (do_deq) begin
                rf_rd    <= head_e.rd;
                rf_wdata <= head_e.is_load ? al_wdata : head_e.result;
                instret  <= instret + 1'b1;
                if (head_e.is_load && al_mis) misalign_err <= 1'b1;
            end
        end
    end

`ifdef WB_COMMIT_RVFI_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rvfi_o <= '0;
        end else begin
            rvfi_o.valid <= do_deq;
            if (do_deq) begin
                rvfi_o.insn      <= head_e.insn;
                rvfi_o.rs1_addr  <= head_e.rs1;
                rvfi_o.rs2_addr  <= head_e.rs2;
                rvfi_o.rd_addr   <= head_e.rd;
                rvfi_o.rd_wdata  <= (head_e.rd == 5'd0) ? 32'h0 :
                                    (head_e.is_load ? al_wdata : head_e.result);
                rvfi_o.pc_rdata  <= head_e.pc;
                rvfi_o.pc_wdata  <= head_e.pc_wdata;
                rvfi_o.mem_addr  <= head_e.mem_addr;
                rvfi_o.mem_rmask <= head_e.is_load ? (head_e.mem_rmask << head_e.addr_lo)
                                                   : head_e.mem_rmask;
                rvfi_o.mem_wmask <= head_e.mem_wmask;
                rvfi_o.mem_wdata <= head_e.mem_wdata;
            end
        end
    end
`endif

    // Mask is built from registered state only; slot i is live when its
    // distance from head is below count.
    always_comb begin
        pending_mask = '0;
        off          = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - head;
            if (({1'b0, off} < count) && q[i].load_rf) pending_mask[q[i].rd] = 1'b1;
        end
        if (rf_we) pending_mask[rf_rd] = 1'b1;
        pending_mask[0] = 1'b0;
    end

endmodule

// File: tb/tb_wb_commit_queue.sv
module tb_wb_commit_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, in_valid, in_ready, in_load_rf, in_is_load, wb_stall, rf_we, misalign_err;
    logic [31:0] in_pc, in_result, in_rdata, rf_wdata, pending_mask;
    logic [4:0]  in_rd, rf_rd;
    logic [2:0]  in_funct3;
    logic [1:0]  in_addr_lo;
    logic [63:0] instret;

    wb_commit_queue #(.XLEN(32), .DEPTH(DEPTH), .CNT_W(64)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_rd(in_rd), .in_load_rf(in_load_rf), .in_is_load(in_is_load), .in_funct3(in_funct3),
        .in_addr_lo(in_addr_lo), .in_result(in_result), .in_rdata(in_rdata), .wb_stall(wb_stall),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata), .pending_mask(pending_mask),
        .instret(instret), .misalign_err(misalign_err)
    );

    typedef struct {
        logic [4:0]  rd;
        logic        wr;
        logic        ld;
        logic [2:0]  f3;
        logic [1:0]  lo;
        logic [31:0] res;
        logic [31:0] rdat;
    } ent_t;
    typedef struct { logic [4:0] rd; logic [31:0] data; } wr_t;
    typedef struct { logic [31:0] data; logic mis; } al_t;

    int checks = 0;
    int errors = 0;

    ent_t        mq[$];
    wr_t         exp_q[$];
    logic        m_we = 1'b0;
    logic [4:0]  m_out_rd = 5'd0;
    logic [63:0] m_instret = 64'd0;
    logic        m_mis = 1'b0;
    bit          started = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference load semantics written directly from the ISA rules.
    function automatic al_t ref_align(input ent_t e);
        al_t r;
        logic [31:0] b, h;
        r.mis = 1'b0;
        r.data = e.res;
        if (!e.ld) return r;
        b = (e.rdat >> (8 * int'(e.lo))) & 32'hFF;
        h = (e.rdat >> (16 * (int'(e.lo) / 2))) & 32'hFFFF;
        case (e.f3)
            3'd0: r.data = (b >= 32'd128) ? b + 32'hFFFFFF00 : b;
            3'd4: r.data = b;
            3'd1: begin r.data = (h >= 32'd32768) ? h + 32'hFFFF0000 : h; r.mis = (e.lo % 2 == 1); end
            3'd5: begin r.data = h; r.mis = (e.lo % 2 == 1); end
            default: begin r.data = e.rdat; r.mis = (e.lo != 2'd0); end
        endcase
        return r;
    endfunction

    function automatic ent_t cur();
        ent_t e;
        e.rd = in_rd; e.wr = in_load_rf; e.ld = in_is_load; e.f3 = in_funct3;
        e.lo = in_addr_lo; e.res = in_result; e.rdat = in_rdata;
        return e;
    endfunction

    // Reference model: a plain FIFO of instructions. Expected writes are
    // scoreboarded at issue time.
    always @(posedge clk) begin
        ent_t h, e;
        bit deq, enq;
        if (!rst_n) begin
            mq.delete(); exp_q.delete();
            m_we = 1'b0; m_instret = 64'd0; m_mis = 1'b0; started = 1'b1;
        end else if (started) begin
            deq = (mq.size() > 0) && !wb_stall;
            enq = in_valid && (mq.size() < DEPTH);
            m_we = 1'b0;
            if (deq) begin
                h = mq.pop_front();
                m_instret = m_instret + 64'd1;
                m_we = h.wr && (h.rd != 5'd0);
                m_out_rd = h.rd;
                if (h.ld && ref_align(h).mis) m_mis = 1'b1;
            end
            if (enq) begin
                e = cur();
                mq.push_back(e);
                if (e.wr && e.rd != 5'd0) exp_q.push_back('{e.rd, ref_align(e).data});
            end
        end
    end

    // Monitor: per-cycle state checks plus scoreboard pop on every write.
    always @(negedge clk) begin
        logic [31:0] em;
        wr_t w;
        if (started) begin
            em = 32'd0;
            foreach (mq[i]) if (mq[i].wr) em[mq[i].rd] = 1'b1;
            if (m_we) em[m_out_rd] = 1'b1;
            em[0] = 1'b0;
            chk("in_ready", 64'(in_ready), 64'(mq.size() < DEPTH));
            chk("instret", instret, m_instret);
            chk("misalign_err", 64'(misalign_err), 64'(m_mis));
            chk("pending_mask", 64'(pending_mask), 64'(em));
            chk("rf_we", 64'(rf_we), 64'(m_we));
            if (rf_we) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wb_extra: write x%0d=0x%0h with nothing expected", rf_rd, rf_wdata);
                end else begin
                    w = exp_q.pop_front();
                    chk("wb_rd", 64'(rf_rd), 64'(w.rd));
                    chk("wb_data", 64'(rf_wdata), 64'(w.data));
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [4:0] rd, input logic wr, input logic ld,
                         input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] res,
                         input logic [31:0] rdat);
        in_valid = v; in_rd = rd; in_load_rf = wr; in_is_load = ld; in_funct3 = f3;
        in_addr_lo = lo; in_result = res; in_rdata = rdat; in_pc = $urandom;
    endtask

    task automatic send(input logic [4:0] rd, input logic wr, input logic ld, input logic [2:0] f3,
                        input logic [1:0] lo, input logic [31:0] res, input logic [31:0] rdat);
        drive(1'b1, rd, wr, ld, f3, lo, res, rdat);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_wd(input string name, input logic [31:0] exp);
        bit seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (rf_we) seen = 1'b1;
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL %s: no rf_we within 10 cycles, expected data 0x%0h", name, exp);
        end else chk(name, 64'(rf_wdata), 64'(exp));
    endtask

    initial begin
        logic [63:0] i0;
        int wcnt;
        logic [2:0] f3tab [7];
        f3tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6};
        rst_n = 1'b0; wb_stall = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 2'd0, 32'd0, 32'd0);
        repeat (2) @(negedge clk);
        chk("reset_rf_we", 64'(rf_we), 64'd0);
        chk("reset_rf_wdata", 64'(rf_wdata), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;

        // Reset with three entries queued.
        wb_stall = 1'b1;
        for (int k = 0; k < 3; k++) send(5'(k + 3), 1'b1, 1'b0, 3'd0, 2'd0, $urandom, 32'd0);
        chk("pre_reset_mask", 64'(pending_mask), 64'h38);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; wb_stall = 1'b0;
        chk("rst_instret", instret, 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_mask", 64'(pending_mask), 64'd0);
        wcnt = 0;
        repeat (4) begin @(negedge clk); if (rf_we) wcnt++; end
        chk("rst_no_writes", 64'(wcnt), 64'd0);

        // Load extraction vectors.
        send(5'd1, 1'b1, 1'b1, 3'd0, 2'd2, 32'd0, 32'h12803456); wait_wd("lb_a2", 32'hFFFFFF80);
        send(5'd2, 1'b1, 1'b1, 3'd4, 2'd2, 32'd0, 32'h12803456); wait_wd("lbu_a2", 32'h00000080);
        send(5'd3, 1'b1, 1'b1, 3'd5, 2'd2, 32'd0, 32'h12803456); wait_wd("lhu_a2", 32'h00001280);
        chk("no_misalign_yet", 64'(misalign_err), 64'd0);
        send(5'd4, 1'b1, 1'b1, 3'd1, 2'd3, 32'd0, 32'h80010000); wait_wd("lh_a3", 32'hFFFF8001);
        @(negedge clk);
        chk("misalign_set", 64'(misalign_err), 64'd1);
        send(5'd6, 1'b1, 1'b0, 3'd0, 2'd0, 32'h55, 32'd0); wait_wd("add_after", 32'h55);
        chk("misalign_sticky", 64'(misalign_err), 64'd1);

        // Fill with commit held; fifth instruction must be refused.
        wb_stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 5'(10 + k), 1'b1, 1'b0, 3'd0, 2'd0, 32'(100 + k), 32'd0);
            @(negedge clk);
            if (k == 3) chk("full_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        i0 = instret;
        wb_stall = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("drain_we", 64'(rf_we), 64'd1);
            chk("drain_rd", 64'(rf_rd), 64'(10 + k));
        end
        @(negedge clk);
        chk("drain_done", 64'(rf_we), 64'd0);
        chk("drain_instret", instret, i0 + 64'd4);

        // rd=0 ADDI and rd=5 ADD.
        wb_stall = 1'b1;
        send(5'd0, 1'b1, 1'b0, 3'd0, 2'd0, 32'h7, 32'd0);
        send(5'd5, 1'b1, 1'b0, 3'd0, 2'd0, 32'h9, 32'd0);
        chk("rd0_mask", 64'(pending_mask), 64'h20);
        i0 = instret; wcnt = 0;
        wb_stall = 1'b0;
        repeat (4) begin @(negedge clk); if (rf_we) wcnt++; end
        chk("rd0_writes", 64'(wcnt), 64'd1);
        chk("rd0_instret", instret, i0 + 64'd2);
        chk("rd0_mask_clear", 64'(pending_mask), 64'd0);

        // Back-to-back traffic through the pointer wrap.
        for (int k = 0; k < 2 * DEPTH + 1; k++) begin
            drive(1'b1, 5'(1 + k), 1'b1, 1'b0, 3'd0, 2'd0, $urandom, 32'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (4) @(negedge clk);

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            drive(1'b1, 5'($urandom_range(0, 31)), 1'($urandom), 1'($urandom),
                  f3tab[$urandom_range(0, 6)], 2'($urandom), $urandom, $urandom);
            in_valid = ($urandom_range(0, 3) != 0);
            wb_stall = ($urandom_range(0, 3) == 0);
            @(negedge clk);
        end
        in_valid = 1'b0; wb_stall = 1'b0;
        repeat (8) @(negedge clk);
        chk("sb_empty", 64'(exp_q.size()), 64'd0);

        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("final_misalign", 64'(misalign_err), 64'd0);
        chk("final_instret", instret, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
